// File: rtl/pid_scheduler_if.sv
// pid_scheduler_if: bus between the control unit (UC) and pid_scheduler.
//   UC -> scheduler : DA, flag_saveProc, flag_restoreProc, flag_activate,
//                     flag_kill, sched_en, quantum, switch_ack
//   scheduler -> UC : process, next_process, switch_req, active_mask,
//                     stack_full, stack_empty, quantum_left
// The master modport is the UC side; the slave modport is the scheduler.
interface pid_scheduler_if #(
  parameter int PID_W     = 4,
  parameter int QUANTUM_W = 8
);
  localparam int NPROC = 2 ** PID_W;

  logic [31:0]          DA;
  logic                 flag_saveProc;
  logic                 flag_restoreProc;
  logic                 flag_activate;
  logic                 flag_kill;
  logic                 sched_en;
  logic [QUANTUM_W-1:0] quantum;
  logic                 switch_ack;

  logic [PID_W-1:0]     process;
  logic [PID_W-1:0]     next_process;
  logic                 switch_req;
  logic [NPROC-1:0]     active_mask;
  logic                 stack_full;
  logic                 stack_empty;
  logic [QUANTUM_W-1:0] quantum_left;

  modport master (
    output DA, flag_saveProc, flag_restoreProc, flag_activate, flag_kill,
           sched_en, quantum, switch_ack,
    input  process, next_process, switch_req, active_mask, stack_full,
           stack_empty, quantum_left
  );

  modport slave (
    input  DA, flag_saveProc, flag_restoreProc, flag_activate, flag_kill,
           sched_en, quantum, switch_ack,
    output process, next_process, switch_req, active_mask, stack_full,
           stack_empty, quantum_left
  );
endinterface

// File: rtl/pid_scheduler.sv
// pid_scheduler: scheduling-aware process context block.
// Holds the running PID, a LIFO of interrupted PIDs (nested save/restore),
// an active-process mask, a quantum timer that raises a sticky preemption
// request, and the round-robin successor PID.
// Ports:
//   clk   - single clock, all state updates on the rising edge
//   rst_n - synchronous active-low reset
//   bus   - pid_scheduler_if.slave (UC flags, DA, quantum in; PID state out)
module pid_scheduler #(
  parameter int PID_W       = 4,
  parameter int STACK_DEPTH = 4,
  parameter int QUANTUM_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  pid_scheduler_if.slave   bus
);
  localparam int NPROC = 2 ** PID_W;
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [PID_W-1:0]     process_reg, process_next;
  logic [NPROC-1:0]     mask_reg, mask_next;
  logic [SP_W-1:0]      sp_reg, sp_next;
  logic                 full_reg, empty_reg;
  logic                 switch_req_reg, switch_req_next;
  logic [QUANTUM_W-1:0] quantum_left_reg, quantum_left_next;
  logic [PID_W-1:0]     stack_mem [STACK_DEPTH];
  logic [PID_W-1:0]     next_pid;

  logic [PID_W-1:0]     da_pid;
  logic [QUANTUM_W-1:0] quantum_load;
  logic                 do_save, do_restore, do_switch, do_push, updated;
  logic [IDX_W-1:0]     wr_idx, rd_idx;
  logic                 unused_da_bits;

  assign da_pid         = bus.DA[PID_W-1:0];
  assign unused_da_bits = ^bus.DA[31:PID_W];
  assign quantum_load   = (bus.quantum == '0) ? QUANTUM_W'(1) : bus.quantum;

  // Priority: save > restore > acknowledged switch. A raised restore flag
  // blocks a switch even when the LIFO is empty and the restore is a no-op.
  assign do_save    = bus.flag_saveProc;
  assign do_restore = !bus.flag_saveProc && bus.flag_restoreProc && !empty_reg;
  assign do_switch  = !bus.flag_saveProc && !bus.flag_restoreProc &&
                      bus.switch_ack && switch_req_reg;
  assign do_push    = do_save && !full_reg;
  assign updated    = do_save || do_restore || do_switch;

  assign wr_idx = IDX_W'(sp_reg);
  assign rd_idx = IDX_W'(sp_reg - SP_W'(1));

  // Round-robin successor: first active PID after the current one, wrapping;
  // falls back to the current PID when nothing else is active.
  always_comb begin
    logic [PID_W-1:0] cand;
    logic             found;
    next_pid = process_reg;
    found    = 1'b0;
    cand     = '0;
    for (int i = 1; i < NPROC; i++) begin
      cand = process_reg + PID_W'(i);
      if (!found && mask_reg[cand]) begin
        next_pid = cand;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    process_next      = process_reg;
    sp_next           = sp_reg;
    mask_next         = mask_reg;
    switch_req_next   = switch_req_reg;
    quantum_left_next = quantum_left_reg;

    if (do_save) begin
      process_next = da_pid;
      if (do_push) sp_next = sp_reg + SP_W'(1);
    end else if (do_restore) begin
      process_next = stack_mem[rd_idx];
      sp_next      = sp_reg - SP_W'(1);
    end else if (do_switch) begin
      process_next = next_pid;
    end

    // Kill is applied after activate so it wins on the same index.
    if (bus.flag_activate) mask_next[da_pid] = 1'b1;
    if (bus.flag_kill)     mask_next[da_pid] = 1'b0;

    if (updated) begin
      quantum_left_next = quantum_load;
      switch_req_next   = 1'b0;
    end else if (switch_req_reg) begin
      // Pending preemption: counter parks at zero until acknowledged.
      quantum_left_next = '0;
    end else if (!bus.sched_en) begin
      quantum_left_next = quantum_load;
    end else if (quantum_left_reg <= QUANTUM_W'(1)) begin
      quantum_left_next = '0;
      switch_req_next   = 1'b1;
    end else begin
      quantum_left_next = quantum_left_reg - QUANTUM_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      process_reg      <= '0;
      mask_reg         <= NPROC'(1);
      sp_reg           <= '0;
      full_reg         <= 1'b0;
      empty_reg        <= 1'b1;
      switch_req_reg   <= 1'b0;
      quantum_left_reg <= '0;
    end else begin
      process_reg      <= process_next;
      mask_reg         <= mask_next;
      sp_reg           <= sp_next;
      full_reg         <= (sp_next == SP_W'(STACK_DEPTH));
      empty_reg        <= (sp_next == '0);
      switch_req_reg   <= switch_req_next;
      quantum_left_reg <= quantum_left_next;
    end
  end

  // LIFO storage; the stack pointer alone defines validity, so no reset.
  always_ff @(posedge clk) begin
    if (rst_n && do_push) stack_mem[wr_idx] <= process_reg;
  end

  assign bus.process      = process_reg;
  assign bus.next_process = next_pid;
  assign bus.switch_req   = switch_req_reg;
  assign bus.active_mask  = mask_reg;
  assign bus.stack_full   = full_reg;
  assign bus.stack_empty  = empty_reg;
  assign bus.quantum_left = quantum_left_reg;
endmodule

// File: tb/tb_pid_scheduler.sv
module tb_pid_scheduler;
  localparam int PID_W = 4;
  localparam int QW    = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pid_scheduler_if #(.PID_W(PID_W), .QUANTUM_W(QW)) bus ();

  pid_scheduler #(.PID_W(PID_W), .STACK_DEPTH(4), .QUANTUM_W(QW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic       save, restore, act, kill, ack;
    logic [3:0] da;
    logic [3:0] exp_proc, exp_next;
    logic [15:0] exp_mask;
    logic       exp_full, exp_empty;
  } vec_t;

  vec_t vecs [27];
  vec_t sb_q [$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic s, r, a, k, ack, input logic [3:0] da,
                              input logic [3:0] p, n, input logic [15:0] m,
                              input logic f, e);
    vec_t v;
    v.save = s; v.restore = r; v.act = a; v.kill = k; v.ack = ack; v.da = da;
    v.exp_proc = p; v.exp_next = n; v.exp_mask = m; v.exp_full = f; v.exp_empty = e;
    return v;
  endfunction

  task automatic idle();
    bus.flag_saveProc = 0; bus.flag_restoreProc = 0; bus.flag_activate = 0;
    bus.flag_kill = 0; bus.switch_ack = 0;
  endtask

  task automatic step(input logic s, r, a, k, ack, input logic [3:0] da);
    @(negedge clk);
    bus.flag_saveProc = s; bus.flag_restoreProc = r; bus.flag_activate = a;
    bus.flag_kill = k; bus.switch_ack = ack;
    bus.DA = {28'hABCDEF1, da};
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t v;
    int edges;
    // Nested save/restore
    vecs[0]  = mk(1,0,0,0,0, 5,  5, 0, 16'h0001, 0, 0);
    vecs[1]  = mk(1,0,0,0,0, 9,  9, 0, 16'h0001, 0, 0);
    vecs[2]  = mk(0,1,0,0,0, 0,  5, 0, 16'h0001, 0, 0);
    vecs[3]  = mk(0,1,0,0,0, 0,  0, 0, 16'h0001, 0, 1);
    vecs[4]  = mk(0,1,0,0,0, 0,  0, 0, 16'h0001, 0, 1);
    // LIFO overflow: PID 4 is lost
    vecs[5]  = mk(1,0,0,0,0, 1,  1, 0, 16'h0001, 0, 0);
    vecs[6]  = mk(1,0,0,0,0, 2,  2, 0, 16'h0001, 0, 0);
    vecs[7]  = mk(1,0,0,0,0, 3,  3, 0, 16'h0001, 0, 0);
    vecs[8]  = mk(1,0,0,0,0, 4,  4, 0, 16'h0001, 1, 0);
    vecs[9]  = mk(1,0,0,0,0, 5,  5, 0, 16'h0001, 1, 0);
    vecs[10] = mk(0,1,0,0,0, 0,  3, 0, 16'h0001, 0, 0);
    vecs[11] = mk(0,1,0,0,0, 0,  2, 0, 16'h0001, 0, 0);
    vecs[12] = mk(0,1,0,0,0, 0,  1, 0, 16'h0001, 0, 0);
    vecs[13] = mk(0,1,0,0,0, 0,  0, 0, 16'h0001, 0, 1);
    // Round robin and mask updates
    vecs[14] = mk(0,0,1,0,0, 3,  0, 3, 16'h0009, 0, 1);
    vecs[15] = mk(0,0,1,0,0, 7,  0, 3, 16'h0089, 0, 1);
    vecs[16] = mk(0,0,1,0,0, 12, 0, 3, 16'h1089, 0, 1);
    vecs[17] = mk(1,0,0,0,0, 7,  7, 12, 16'h1089, 0, 0);
    vecs[18] = mk(1,0,0,0,0, 12, 12, 0, 16'h1089, 0, 0);
    vecs[19] = mk(0,0,1,1,0, 3,  12, 0, 16'h1081, 0, 0);
    vecs[20] = mk(0,0,0,1,0, 12, 12, 0, 16'h0081, 0, 0);
    vecs[21] = mk(0,1,0,0,0, 0,  7, 0, 16'h0081, 0, 0);
    vecs[22] = mk(0,1,0,0,0, 0,  0, 7, 16'h0081, 0, 1);
    // Simultaneous save/restore/ack: one push only
    vecs[23] = mk(1,1,0,0,1, 6,  6, 7, 16'h0081, 0, 0);
    vecs[24] = mk(0,1,0,0,0, 0,  0, 7, 16'h0081, 0, 1);
    vecs[25] = mk(0,0,1,0,0, 2,  0, 2, 16'h0085, 0, 1);
    // Ack without a pending request is ignored
    vecs[26] = mk(0,0,0,0,1, 0,  0, 2, 16'h0085, 0, 1);

    idle();
    bus.DA = '0; bus.sched_en = 0; bus.quantum = 8'd5;
    rst_n = 0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_process", 32'(bus.process), 0);
    check("rst_mask", 32'(bus.active_mask), 32'h0001);
    check("rst_empty", 32'(bus.stack_empty), 1);
    check("rst_full", 32'(bus.stack_full), 0);
    check("rst_switch_req", 32'(bus.switch_req), 0);
    check("rst_quantum_left", 32'(bus.quantum_left), 0);
    @(negedge clk); rst_n = 1;

    for (int i = 0; i < 27; i++) begin
      v = vecs[i];
      @(negedge clk);
      bus.flag_saveProc = v.save; bus.flag_restoreProc = v.restore;
      bus.flag_activate = v.act; bus.flag_kill = v.kill; bus.switch_ack = v.ack;
      bus.DA = {28'hABCDEF1, v.da};
      sb_q.push_back(v);
      @(posedge clk); #1;
      v = sb_q.pop_front();
      check($sformatf("v%0d_process", i), 32'(bus.process), 32'(v.exp_proc));
      check($sformatf("v%0d_next", i), 32'(bus.next_process), 32'(v.exp_next));
      check($sformatf("v%0d_mask", i), 32'(bus.active_mask), 32'(v.exp_mask));
      check($sformatf("v%0d_full", i), 32'(bus.stack_full), 32'(v.exp_full));
      check($sformatf("v%0d_empty", i), 32'(bus.stack_empty), 32'(v.exp_empty));
      check($sformatf("v%0d_qleft", i), 32'(bus.quantum_left), 5);
      $display("[TB] vec %0d process=%0d next=%0d mask=%04h", i, bus.process,
               bus.next_process, bus.active_mask);
    end
    idle();

    // Quantum = 3: request exactly 3 edges after sched_en rises
    @(negedge clk); bus.quantum = 8'd3; bus.sched_en = 0;
    @(posedge clk); #1;
    check("q3_load", 32'(bus.quantum_left), 3);
    @(negedge clk); bus.sched_en = 1;
    edges = 0;
    while (!bus.switch_req && edges < 20) begin
      @(posedge clk); #1; edges++;
    end
    check("q3_edges", 32'(edges), 3);
    check("q3_qleft_zero", 32'(bus.quantum_left), 0);
    check("q3_next", 32'(bus.next_process), 2);
    step(0,0,0,0,1, 0);
    check("ack_process", 32'(bus.process), 2);
    check("ack_switch_req", 32'(bus.switch_req), 0);
    check("ack_qleft", 32'(bus.quantum_left), 3);
    step(0,0,0,0,1, 0);
    check("ack_extra_process", 32'(bus.process), 2);
    check("ack_extra_qleft", 32'(bus.quantum_left), 2);
    $display("[TB] quantum=3 switch after %0d edges, process=%0d", edges, bus.process);

    // Quantum = 0 behaves as 1
    @(negedge clk); idle(); bus.sched_en = 0; bus.quantum = 8'd0;
    @(posedge clk); #1;
    check("q0_load", 32'(bus.quantum_left), 1);
    @(negedge clk); bus.sched_en = 1;
    @(posedge clk); #1;
    check("q0_switch_req", 32'(bus.switch_req), 1);
    $display("[TB] quantum=0 switch_req=%0d after one edge", bus.switch_req);

    // Empty mask: successor falls back to the current PID
    @(negedge clk); bus.sched_en = 0;
    step(0,0,0,1,0, 0);
    step(0,0,0,1,0, 7);
    check("solo_next", 32'(bus.next_process), 2);
    step(0,0,0,1,0, 2);
    check("empty_mask", 32'(bus.active_mask), 0);
    check("empty_next", 32'(bus.next_process), 2);
    check("kill_cur_process", 32'(bus.process), 2);
    $display("[TB] empty mask next=%0d", bus.next_process);

    // Reset wins over a simultaneous save
    @(negedge clk); rst_n = 0; bus.flag_saveProc = 1; bus.DA = 32'h9;
    @(posedge clk); #1;
    check("rst_win_process", 32'(bus.process), 0);
    check("rst_win_empty", 32'(bus.stack_empty), 1);
    check("rst_win_mask", 32'(bus.active_mask), 32'h0001);
    check("rst_win_qleft", 32'(bus.quantum_left), 0);
    check("rst_win_switch_req", 32'(bus.switch_req), 0);
    $display("[TB] reset with save process=%0d", bus.process);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pid_scheduler.md
# pid_scheduler

Parametrised process-control unit that replaces the single current-PID register with a scheduling-aware context block. It holds the running process ID, a LIFO of interrupted PIDs for nested save/restore, and an active-process mask. A quantum timer raises a preemption request, and the unit supplies the round-robin next PID. It sits beside the control unit (UC) and register file: PIDs arrive on the register-26 data bus, and `process` feeds the memory-partition and register-bank selection logic.

## Interface
Parameters:
- `PID_W`, 4: PID width; number of processes NPROC = 2^PID_W.
- `STACK_DEPTH`, 4: depth of the saved-PID LIFO (≥1).
- `QUANTUM_W`, 8: width of quantum load value and counter.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `DA`  in  32: register-26 data; only `DA[PID_W-1:0]` is used.
- `flag_saveProc`  in  1: UC saveProc. Push `process`, then load the PID from `DA`.
- `flag_restoreProc`  in  1: UC restoreProc. Pop the LIFO into `process`.
- `flag_activate`  in  1: set mask bit `DA[PID_W-1:0]`.
- `flag_kill`  in  1: clear mask bit `DA[PID_W-1:0]`.
- `sched_en`  in  1: enables quantum countdown.
- `quantum`  in  QUANTUM_W: time-slice length in cycles; 0 is treated as 1.
- `switch_ack`  in  1: UC accepts the preemption and loads `next_process`.
- `process`  out  PID_W: current PID (registered).
- `next_process`  out  PID_W: round-robin successor (combinational from state).
- `switch_req`  out  1: quantum expired (registered, sticky).
- `active_mask`  out  NPROC: active-process bitmap (registered).
- `stack_full`, `stack_empty`  out  1: LIFO status (registered).
- `quantum_left`  out  QUANTUM_W: remaining slice.

## Operation
- **Reset** (`rst_n`=0 at an edge): `process`=0, `active_mask`=1 (only PID 0 active), LIFO empty (`stack_empty`=1, `stack_full`=0), `switch_req`=0, `quantum_left`=0.
- **Process-update priority** per cycle: saveProc > restoreProc > (`switch_ack` & `switch_req`). Lower-priority requests in the same cycle are dropped.
- **Save**: push the old `process` and load `DA[PID_W-1:0]`.
  - If the LIFO is full, the push is discarded, but `process` still loads.
- **Restore**: if the LIFO is non-empty, pop into `process`.
  - If empty: no-op, `process` unchanged.
- **Switch**: on `switch_ack` while `switch_req`=1, `process` <= `next_process`. The LIFO is untouched. `switch_ack` without `switch_req` is ignored.
- **next_process**: first set bit of `active_mask` scanning `process+1, process+2, …` modulo NPROC, excluding `process`.
  - If no other bit is set, it equals `process`, even when the mask is empty.
- **Mask updates**: activate and kill are independent of process updates. If both target the same index in one cycle, kill wins. Killing the current PID does not change `process`; it takes effect at the next switch.
- **Quantum counter**:
  - Any cycle that updates `process` (save, successful restore, switch) loads `quantum_left` <= max(`quantum`,1) and clears `switch_req`.
  - Otherwise, while `sched_en`=0: `quantum_left` <= max(`quantum`,1) each cycle.
  - Otherwise, while `sched_en`=1 and `switch_req`=0: if `quantum_left` ≤ 1, then `quantum_left` <= 0 and `switch_req` <= 1; else decrement.
  - While `switch_req`=1, the counter holds at 0 until acknowledged or reset.

## Timing
- Save, restore and switch have 1-cycle latency: the flag is sampled at edge N, and `process` holds the new value after edge N.
- `next_process` is valid combinationally in the same cycle as the `process`/`active_mask` state it derives from.
- With `sched_en` held high from a load, `switch_req` rises exactly max(`quantum`,1) edges after the load edge.
- A flag and `rst_n`=0 in the same cycle: reset wins.
- `switch_req` and `switch_ack` are level-sampled. The UC must deassert `switch_ack` after one cycle; extra high cycles are ignored because `switch_req` is already 0.

## Test plan
- **Reset**: hold `rst_n`=0 two cycles → `process`=0, `active_mask`=0x0001, `stack_empty`=1, `switch_req`=0, `quantum_left`=0.
- **Nested save/restore**: save DA=5, then DA=9, then restore ×2, then restore again → `process` 5, 9, 5, 0, 0; `stack_empty`=1 at the end.
- **LIFO overflow**: with `STACK_DEPTH`=4, perform 5 saves of PIDs 1..5 → `process`=5 and `stack_full`=1. Then 4 restores → `process` 3, 2, 1, 0; PID 4 is lost.
- **Round robin**: activate 3, 7, 12; from `process`=7 → `next_process`=12. Set `process`=12 → `next_process`=0. Kill 3 and activate 3 in the same cycle → bit 3 cleared.
- **Quantum**: `quantum`=3, `sched_en` rises with `process`=0 and PID 2 active → `switch_req`=1 exactly 3 edges later, `quantum_left`=0. `switch_ack` → `process`=2, `switch_req`=0, `quantum_left`=3.
- **Simultaneous events**: save DA=6 with restore and `switch_ack` in the same cycle → `process`=6 and one push only. `quantum`=0 → `switch_req` one edge after the load.
